muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the multicycle MIPS core. It sits beside the single-cycle ALU.
- Decodes R-type funct for MULT, MULTU, DIV, DIVU, MTHI and MTLO, and computes one bit per clock.
- Exposes HI/LO so the datapath can service MFHI/MFLO directly.
- Parametrised in operand width and uses a start/busy/done handshake toward the control unit.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be 4 or greater.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled at the rising edge together with funct
- funct  input  6  R-type function field
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
- b  input  WIDTH  rt operand (divisor / multiplier)
- busy  output  1  operation in progress; new requests are ignored
- done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle
- hi  output  WIDTH  HI register (product high half / remainder)
- lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Reset:
  - reset_n low forces, asynchronously: state=IDLE, busy=0, done=0, hi=0, lo=0, and clears all internal accumulators and the counter.
  - A reset asserted mid-operation aborts the operation; no partial result survives.
- Funct decode:
  - 011000 MULT (signed)
  - 011001 MULTU
  - 011010 DIV (signed)
  - 011011 DIVU
  - 010001 MTHI
  - 010011 MTLO
  - Any other funct with start=1 is ignored: no state change, no done.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start with MTHI/MTLO: hi (or lo) <= a at that edge; busy and done stay 0; remain in IDLE.
  - start with MULT/MULTU/DIV/DIVU:
    - Latch the operand magnitudes. Signed ops take the absolute value; unsigned ops use the operands unchanged.
    - Latch the result signs, clear counter, go to RUN.
    - busy=1 from the following cycle.
- RUN:
  - Exactly WIDTH cycles, one iteration per edge; counter runs 0..WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle with a WIDTH+1-bit partial remainder.
  - After the WIDTH-th iteration go to FIX.
- FIX (1 cycle):
  - Apply sign correction.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
    - Division truncates toward zero.
  - At the FIX exit edge: write hi/lo, set done=1, busy=0, return to IDLE.
  - done deasserts at the next edge.
- Latency:
  - Request edge E0 -> done high and hi/lo valid after edge E0+WIDTH+1.
  - busy is high for WIDTH+1 cycles.
  - hi/lo are unchanged while busy.
- Start while busy: ignored, whatever the funct, including MTHI/MTLO.
- Start in the done cycle: accepted normally, because the state is already IDLE.
  - The next operation begins; done still drops after one cycle.
- Divide by zero (b=0, signed or unsigned): lo = all ones, hi = a; still takes the full latency.
- Signed overflow (a = most negative, b = -1): lo = most negative, hi = 0; no trap.
- Multiply: {hi,lo} = full 2*WIDTH-bit product; no truncation.

Test Plan:
- MULT, WIDTH=32, a=0xFFFFFFFF, b=0x00000002 -> 33 cycles after the start edge, done=1 with hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE. Repeat MULTU at WIDTH=8 with a=0xFF, b=0xFF -> hi=0xFE, lo=0x01 after 9 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=0x00001234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234, done at cycle 33. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake:
  - MTHI a=0xDEADBEEF in IDLE -> hi=0xDEADBEEF after one edge; busy and done stay 0.
  - During a running MULT, pulse start with DIVU and with MTLO -> both ignored; the MULT result is correct and exactly one done pulse occurs.
  - Back-to-back start in the done cycle -> second operation completes 33 cycles later.
  - Illegal funct 100000 with start -> no change.
- Drop reset_n low in RUN cycle 10 of a DIV -> busy, done, hi and lo are 0 immediately without a clock edge. After release, MULTU 3×5 -> lo=15, hi=0, done after 33 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// One shift-add or restoring-divide step per clock, then a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic is_mul, is_div, is_sgn;
  logic is_mthi, is_mtlo, is_arith;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_sgn  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    case (funct)
      6'b011000: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
      end
      6'b011001: is_mul = 1'b1;
      6'b011010: begin
        is_div = 1'b1;
        is_sgn = 1'b1;
      end
      6'b011011: is_div = 1'b1;
      6'b010001: is_mthi = 1'b1;
      6'b010011: is_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign is_arith = is_mul | is_div;

  logic [WIDTH-1:0] abs_a, abs_b;

  assign abs_a = (is_sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b = (is_sgn && b[WIDTH-1]) ? -b : b;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_sh;
  logic [WIDTH:0] div_diff;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, acc_q[0] ? opb_q
                                   : {WIDTH{1'b0}}};
  assign div_sh   = {rem_q, acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb_q};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign rem_fix  = rneg_q ? -rem_q : rem_q;

  // Divide by zero reports an all-ones quotient regardless of sign.
  assign quo_fix = dz_q  ? {WIDTH{1'b1}} :
                   neg_q ? -acc_q[WIDTH-1:0] :
                           acc_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && is_arith) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    rem_d  = rem_q;
    opb_d  = opb_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mthi) hi_d = a;
          if (is_mtlo) lo_d = a;
          if (is_arith) begin
            div_d  = is_div;
            neg_d  = is_sgn
                   & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = is_sgn & a[WIDTH-1];
            dz_d   = is_div && (b == '0);
            opb_d  = abs_b;
            rem_d  = '0;
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            cnt_d  = '0;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (div_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH],
                   acc_q[WIDTH-2:0],
                   ~div_diff[WIDTH]};
          rem_d = div_diff[WIDTH]
                ? div_sh[WIDTH-1:0]
                : div_diff[WIDTH-1:0];
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
      end
      FIX: begin
        done_d = 1'b1;
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      rem_q  <= '0;
      opb_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      opb_q  <= opb_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: 32-bit and 8-bit instances,
// directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start32, start8;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .start(start32), .funct(funct),
    .a(a), .b(b),
    .busy(busy32), .done(done32),
    .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .start(start8), .funct(funct),
    .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [63:0] o,
                     input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, o, e);
    end
  endtask

  function automatic logic [31:0] g_hi(input bit w8);
    return w8 ? {24'h0, hi8} : hi32;
  endfunction

  function automatic logic [31:0] g_lo(input bit w8);
    return w8 ? {24'h0, lo8} : lo32;
  endfunction

  function automatic logic g_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  function automatic logic g_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction

  task automatic model(input logic [5:0] f,
                       input bit w8,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       output logic [31:0] eh,
                       output logic [31:0] el);
    int w;
    logic [63:0] mask, ux, uy, p, q, r;
    longint sx, sy;
    w    = w8 ? 8 : 32;
    mask = w8 ? 64'hFF : 64'hFFFF_FFFF;
    ux   = {32'h0, x} & mask;
    uy   = {32'h0, y} & mask;
    sx   = w8 ? longint'($signed(x[7:0]))
              : longint'($signed(x));
    sy   = w8 ? longint'($signed(y[7:0]))
              : longint'($signed(y));
    p = '0;
    q = '0;
    r = '0;
    if (f == F_MULT || f == F_MULTU) begin
      if (f == F_MULT) p = 64'(sx * sy);
      else             p = ux * uy;
      q = p & mask;
      r = (p >> w) & mask;
    end else if (uy == 0) begin
      q = mask;
      r = ux;
    end else if (f == F_DIV) begin
      q = 64'(sx / sy) & mask;
      r = 64'(sx % sy) & mask;
    end else begin
      q = ux / uy;
      r = ux % uy;
    end
    el = q[31:0];
    eh = r[31:0];
  endtask

  task automatic issue(input bit w8,
                       input logic [5:0] f,
                       input logic [31:0] x,
                       input logic [31:0] y);
    funct = f;
    a = x;
    b = y;
    if (w8) start8 = 1'b1;
    else    start32 = 1'b1;
    @(negedge clk);
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic wait_check(input bit w8,
                            input string tag,
                            input logic [31:0] eh,
                            input logic [31:0] el);
    int n;
    int lat;
    bit ok;
    logic [31:0] ph, pl;
    n   = 0;
    ok  = 1'b1;
    lat = w8 ? 9 : 33;
    ph  = g_hi(w8);
    pl  = g_lo(w8);
    while (!g_done(w8) && n < 200) begin
      if (!g_busy(w8) || g_hi(w8) !== ph
          || g_lo(w8) !== pl) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " busy/hold"}, 64'(ok), 64'(1));
    chk({tag, " hi"}, 64'(g_hi(w8)), 64'(eh));
    chk({tag, " lo"}, 64'(g_lo(w8)), 64'(el));
    chk({tag, " busy@done"}, 64'(g_busy(w8)), 64'(0));
  endtask

  initial begin
    logic [5:0]  ops [4];
    logic [5:0]  f;
    logic [31:0] x, y, eh, el, ph, pl, rh, rl;
    int pulses, dn;

    ops[0] = F_MULT;
    ops[1] = F_MULTU;
    ops[2] = F_DIV;
    ops[3] = F_DIVU;

    reset_n = 1'b0;
    start32 = 1'b0;
    start8  = 1'b0;
    funct   = '0;
    a       = '0;
    b       = '0;
    #1;
    chk("reset busy", 64'(busy32), 64'(0));
    chk("reset done", 64'(done32), 64'(0));
    chk("reset hi", 64'(hi32), 64'(0));
    chk("reset lo", 64'(lo32), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    issue(0, F_MULT, 32'hFFFF_FFFF, 32'h2);
    wait_check(0, "mult -1*2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("done pulse width", 64'(done32), 64'(0));

    issue(0, F_MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_check(0, "multu", 32'h1, 32'hFFFF_FFFE);

    issue(1, F_MULTU, 32'hFF, 32'hFF);
    wait_check(1, "multu8 ff*ff", 32'hFE, 32'h01);

    issue(0, F_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_check(0, "div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(0, F_DIVU, 32'h7, 32'h2);
    wait_check(0, "divu 7/2", 32'h1, 32'h3);

    issue(0, F_DIVU, 32'h1234, 32'h0);
    wait_check(0, "divu by 0", 32'h1234, 32'hFFFF_FFFF);

    issue(0, F_DIV, 32'hFFFF_FF00, 32'h0);
    wait_check(0, "div -256 by 0", 32'hFFFF_FF00,
               32'hFFFF_FFFF);

    issue(0, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_check(0, "div overflow", 32'h0, 32'h8000_0000);

    @(negedge clk);
    pl = lo32;
    issue(0, F_MTHI, 32'hDEAD_BEEF, 32'h0);
    chk("mthi hi", 64'(hi32), 64'(32'hDEAD_BEEF));
    chk("mthi lo", 64'(lo32), 64'(pl));
    chk("mthi busy", 64'(busy32), 64'(0));
    chk("mthi done", 64'(done32), 64'(0));

    ph = hi32;
    pl = lo32;
    issue(0, 6'b100000, 32'h1, 32'h2);
    chk("illegal busy", 64'(busy32), 64'(0));
    chk("illegal done", 64'(done32), 64'(0));
    chk("illegal hi", 64'(hi32), 64'(ph));
    chk("illegal lo", 64'(lo32), 64'(pl));
    repeat (2) @(negedge clk);
    chk("illegal later busy", 64'(busy32), 64'(0));

    x = 32'h1234_5678;
    y = 32'hFFFF_FF00;
    model(F_MULT, 0, x, y, eh, el);
    issue(0, F_MULT, x, y);
    pulses = 0;
    dn = 0;
    rh = '0;
    rl = '0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin
        funct = F_DIVU;
        a = 32'h7;
        b = 32'h2;
        start32 = 1'b1;
      end
      if (i == 6) start32 = 1'b0;
      if (i == 10) begin
        funct = F_MTLO;
        a = 32'hCAFE_F00D;
        start32 = 1'b1;
      end
      if (i == 11) start32 = 1'b0;
      @(negedge clk);
      if (done32) begin
        pulses++;
        dn = i;
        rh = hi32;
        rl = lo32;
      end
    end
    chk("busy-ignore pulses", 64'(pulses), 64'(1));
    chk("busy-ignore latency", 64'(dn), 64'(33));
    chk("busy-ignore hi", 64'(rh), 64'(eh));
    chk("busy-ignore lo", 64'(rl), 64'(el));

    issue(0, F_DIVU, 32'd100, 32'd7);
    wait_check(0, "b2b first", 32'd2, 32'd14);
    issue(0, F_MULTU, 32'd6, 32'd7);
    chk("b2b done drop", 64'(done32), 64'(0));
    chk("b2b busy", 64'(busy32), 64'(1));
    wait_check(0, "b2b second", 32'd0, 32'd42);

    for (int i = 0; i < 10; i++) begin
      f = ops[$urandom_range(0, 3)];
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'h0;
        1: y = 32'($urandom_range(1, 9));
        2: y = -32'($urandom_range(1, 9));
        default: ;
      endcase
      model(f, 0, x, y, eh, el);
      issue(0, f, x, y);
      wait_check(0, $sformatf("rnd32 f=%b a=%h b=%h",
                 f, x, y), eh, el);
    end

    for (int i = 0; i < 10; i++) begin
      f = ops[$urandom_range(0, 3)];
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      if ($urandom_range(0, 4) == 0) y = 32'h0;
      if ($urandom_range(0, 4) == 0) x = 32'h80;
      model(f, 1, x, y, eh, el);
      issue(1, f, x, y);
      wait_check(1, $sformatf("rnd8 f=%b a=%h b=%h",
                 f, x, y), eh, el);
    end

    issue(0, F_MTLO, 32'h0000_5A5A, 32'h0);
    issue(0, F_DIV, 32'h0001_0000, 32'h3);
    repeat (10) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy32), 64'(0));
    chk("async rst done", 64'(done32), 64'(0));
    chk("async rst hi", 64'(hi32), 64'(0));
    chk("async rst lo", 64'(lo32), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post rst busy", 64'(busy32), 64'(0));
    issue(0, F_MULTU, 32'd3, 32'd5);
    wait_check(0, "post rst multu 3*5", 32'd0, 32'd15);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
